// File: rtl/latency_pkg.sv
// latency_pkg: shared types and sizing helpers for the latency
// statistics engine (slot-state enum, window length, sum width).
package latency_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_LOG_WIN = 4;
    localparam int WIN         = 2 ** DEF_LOG_WIN;
    localparam int SUM_W       = DEF_WIDTH + DEF_LOG_WIN;

    // Window length in samples for a given log2 size.
    function automatic int win_len(input int log_win);
        return 2 ** log_win;
    endfunction

    // Accumulator width that cannot overflow over one window.
    function automatic int sum_width(input int width, input int log_win);
        return width + log_win;
    endfunction

endpackage

// File: rtl/latency_stats_if.sv
// latency_stats_if: valid/ready result port carrying min/max/avg.
// master: stats engine drives valid and data; slave: consumer drives ready.
interface latency_stats_if #(
    parameter int WIDTH = 16
);
    logic             stat_valid;
    logic             stat_ready;
    logic [WIDTH-1:0] stat_min;
    logic [WIDTH-1:0] stat_max;
    logic [WIDTH-1:0] stat_avg;

    modport master (
        output stat_valid,
        output stat_min,
        output stat_max,
        output stat_avg,
        input  stat_ready
    );

    modport slave (
        input  stat_valid,
        input  stat_min,
        input  stat_max,
        input  stat_avg,
        output stat_ready
    );
endinterface

// File: rtl/latency_window_acc.sv
// latency_window_acc: min/max/sum/count accumulators over a 2^LOG_WIN window.
// Ports: clk, reset (async low), i_sample, i_value, i_clear;
//        o_done strobe with o_min/o_max/o_avg including the current sample.
module latency_window_acc
    import latency_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LOG_WIN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_sample,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_clear,
    output logic             o_done,
    output logic [WIDTH-1:0] o_min,
    output logic [WIDTH-1:0] o_max,
    output logic [WIDTH-1:0] o_avg
);

    localparam int SW = sum_width(WIDTH, LOG_WIN);
    localparam int WL = win_len(LOG_WIN);
    localparam logic [LOG_WIN-1:0] CNT_LAST = LOG_WIN'(WL - 1);

    logic [WIDTH-1:0]   r_min;
    logic [WIDTH-1:0]   r_max;
    logic [SW-1:0]      r_sum;
    logic [LOG_WIN-1:0] r_cnt;

    logic             w_take;
    logic [WIDTH-1:0] w_min;
    logic [WIDTH-1:0] w_max;
    logic [SW-1:0]    w_sum;
    logic [SW-1:0]    w_sum_sh;

    // A sample coincident with clear is dropped.
    assign w_take   = i_sample && !i_clear;
    assign w_min    = (i_value < r_min) ? i_value : r_min;
    assign w_max    = (i_value > r_max) ? i_value : r_max;
    assign w_sum    = r_sum + SW'(i_value);
    assign w_sum_sh = w_sum >> LOG_WIN;

    assign o_done = w_take && (r_cnt == CNT_LAST);
    assign o_min  = w_min;
    assign o_max  = w_max;
    assign o_avg  = w_sum_sh[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_min <= '1;
            r_max <= '0;
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_clear || o_done) begin
            r_min <= '1;
            r_max <= '0;
            r_sum <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_min <= w_min;
            r_max <= w_max;
            r_sum <= w_sum;
            r_cnt <= r_cnt + LOG_WIN'(1);
        end
    end

endmodule

// File: rtl/latency_stats.sv
// latency_stats: samples upstream latency on running falling edges and
// reports per-window min/max/mean through a valid/ready slot.
// Ports: clk, reset (async low), running_in, latency_in, clear,
//        stat (result interface, master), overrun (sticky drop flag).
module latency_stats
    import latency_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LOG_WIN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             running_in,
    input  logic [WIDTH-1:0] latency_in,
    input  logic             clear,
    latency_stats_if.master  stat,
    output logic             overrun
);

    logic             r_running_q;
    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_avg;
    logic             r_overrun;

    logic             w_event;
    logic             w_done;
    logic             w_hs;
    logic             w_load;
    logic             w_ovr_set;
    logic [WIDTH-1:0] w_min;
    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_avg;

    // Upstream updates latency on the edge that drops running,
    // so the value seen on the falling edge is the final count.
    assign w_event = r_running_q && !running_in;

    latency_window_acc #(
        .WIDTH   (WIDTH),
        .LOG_WIN (LOG_WIN)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .i_sample (w_event),
        .i_value  (latency_in),
        .i_clear  (clear),
        .o_done   (w_done),
        .o_min    (w_min),
        .o_max    (w_max),
        .o_avg    (w_avg)
    );

    assign w_hs = (r_state == FULL) && stat.stat_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ovr_set   = 1'b0;
        if (clear) begin
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_done) begin
                        w_load      = 1'b1;
                        w_state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (w_done && w_hs) begin
                        w_load = 1'b1;
                    end else if (w_done) begin
                        w_ovr_set = 1'b1;
                    end else if (w_hs) begin
                        w_state_nxt = EMPTY;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_running_q <= 1'b0;
            r_state     <= EMPTY;
            r_min       <= '0;
            r_max       <= '0;
            r_avg       <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_running_q <= running_in;
            r_state     <= w_state_nxt;
            if (w_load) begin
                r_min <= w_min;
                r_max <= w_max;
                r_avg <= w_avg;
            end
            if (clear) begin
                r_overrun <= 1'b0;
            end else if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign stat.stat_valid = (r_state == FULL);
    assign stat.stat_min   = r_min;
    assign stat.stat_max   = r_max;
    assign stat.stat_avg   = r_avg;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_latency_stats.sv
// tb_latency_stats: directed table-driven bench for latency_stats
// with LOG_WIN=2, plus hand-written multi-cycle corner sequences.
module tb_latency_stats;

    localparam int W  = 16;
    localparam int LW = 2;

    logic         clk;
    logic         reset;
    logic         running_in;
    logic [W-1:0] latency_in;
    logic         clear;
    logic         overrun;

    latency_stats_if #(.WIDTH(W)) u_if ();

    latency_stats #(
        .WIDTH   (W),
        .LOG_WIN (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .running_in (running_in),
        .latency_in (latency_in),
        .clear      (clear),
        .stat       (u_if),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s0;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic [W-1:0] s3;
        logic [W-1:0] emin;
        logic [W-1:0] emax;
        logic [W-1:0] eavg;
    } vec_t;

    vec_t vecs[5];
    int   n_pass;
    int   n_tot;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One start/stop pulse; returns at the negedge after the sample edge.
    task automatic send(input logic [W-1:0] v);
        @(negedge clk);
        running_in = 1'b1;
        @(negedge clk);
        running_in = 1'b0;
        latency_in = v;
        @(negedge clk);
    endtask

    task automatic send4(input logic [W-1:0] v);
        for (int i = 0; i < 4; i++) send(v);
    endtask

    task automatic accept();
        @(negedge clk);
        u_if.stat_ready = 1'b1;
        @(negedge clk);
        u_if.stat_ready = 1'b0;
    endtask

    task automatic chk_res(input string name, input logic [W-1:0] mn,
                           input logic [W-1:0] mx, input logic [W-1:0] av);
        chk({name, ".valid"}, 32'(u_if.stat_valid), 32'd1);
        chk({name, ".min"}, 32'(u_if.stat_min), 32'(mn));
        chk({name, ".max"}, 32'(u_if.stat_max), 32'(mx));
        chk({name, ".avg"}, 32'(u_if.stat_avg), 32'(av));
    endtask

    initial begin
        n_pass          = 0;
        n_tot           = 0;
        reset           = 1'b0;
        running_in      = 1'b0;
        latency_in      = '0;
        clear           = 1'b0;
        u_if.stat_ready = 1'b0;

        vecs[0] = '{16'd10, 16'd20, 16'd30, 16'd41, 16'd10, 16'd41, 16'd25};
        vecs[1] = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
        vecs[2] = '{16'd0, 16'd100, 16'd3, 16'hFFFF,
                    16'd0, 16'hFFFF, 16'd16409};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                    16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{16'd7, 16'd1, 16'd8, 16'd2, 16'd1, 16'd8, 16'd4};

        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(u_if.stat_valid), 32'd0);
        chk("rst.min", 32'(u_if.stat_min), 32'd0);
        chk("rst.max", 32'(u_if.stat_max), 32'd0);
        chk("rst.avg", 32'(u_if.stat_avg), 32'd0);
        chk("rst.ovr", 32'(overrun), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].s0);
            send(vecs[i].s1);
            send(vecs[i].s2);
            chk($sformatf("v%0d.early", i), 32'(u_if.stat_valid), 32'd0);
            send(vecs[i].s3);
            chk_res($sformatf("v%0d", i), vecs[i].emin, vecs[i].emax,
                    vecs[i].eavg);
            accept();
            chk($sformatf("v%0d.drop", i), 32'(u_if.stat_valid), 32'd0);
        end

        // Overrun: second window dropped while slot is held
        send4(16'd5);
        send4(16'd9);
        chk_res("ovr", 16'd5, 16'd5, 16'd5);
        chk("ovr.flag", 32'(overrun), 32'd1);
        accept();
        chk("ovr.drop", 32'(u_if.stat_valid), 32'd0);
        chk("ovr.sticky", 32'(overrun), 32'd1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr.ovr", 32'(overrun), 32'd0);

        // Completion coincident with handshake
        send4(16'd3);
        send(16'd4);
        send(16'd4);
        send(16'd4);
        @(negedge clk);
        running_in = 1'b1;
        @(negedge clk);
        running_in = 1'b0;
        latency_in = 16'd4;
        u_if.stat_ready = 1'b1;
        @(negedge clk);
        u_if.stat_ready = 1'b0;
        chk_res("coin", 16'd4, 16'd4, 16'd4);
        chk("coin.ovr", 32'(overrun), 32'd0);
        accept();
        chk("coin.drop", 32'(u_if.stat_valid), 32'd0);

        // Clear coincident with a sample edge drops it and prior samples
        send(16'd50);
        send(16'd60);
        @(negedge clk);
        running_in = 1'b1;
        @(negedge clk);
        running_in = 1'b0;
        latency_in = 16'd1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        send(16'd7);
        send(16'd7);
        send(16'd7);
        chk("clr.early", 32'(u_if.stat_valid), 32'd0);
        send(16'd7);
        chk_res("clr", 16'd7, 16'd7, 16'd7);
        accept();

        // Running held high: no samples until it finally drops
        @(negedge clk);
        running_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            latency_in = 16'(i + 200);
            @(negedge clk);
        end
        chk("hold.valid", 32'(u_if.stat_valid), 32'd0);
        running_in = 1'b0;
        latency_in = 16'd3;
        @(negedge clk);
        send(16'd3);
        send(16'd3);
        chk("hold.early", 32'(u_if.stat_valid), 32'd0);
        send(16'd3);
        chk_res("hold", 16'd3, 16'd3, 16'd3);
        accept();

        // Reset mid-FULL and mid-window, with overrun set
        send4(16'd2);
        send4(16'd8);
        send(16'd100);
        send(16'd100);
        chk("pre.ovr", 32'(overrun), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar.valid", 32'(u_if.stat_valid), 32'd0);
        chk("ar.min", 32'(u_if.stat_min), 32'd0);
        chk("ar.max", 32'(u_if.stat_max), 32'd0);
        chk("ar.avg", 32'(u_if.stat_avg), 32'd0);
        chk("ar.ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send(16'd6);
        send(16'd6);
        send(16'd6);
        chk("post.early", 32'(u_if.stat_valid), 32'd0);
        send(16'd6);
        chk_res("post", 16'd6, 16'd6, 16'd6);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/latency_stats.md
# latency_stats

Windowed statistics engine directly downstream of the inference latency counter. It watches the counter's `running`/`latency` pair and captures one latency sample each time a measurement completes. Over a window of 2^LOG_WIN samples it accumulates min, max and sum, then presents min, max and mean through a valid/ready result port to the debug/CSR readout logic.

## Interface
- `WIDTH`, 16: width of the latency sample, matching the upstream counter width.
- `LOG_WIN`, 4: log2 of the window length in samples. Must be ≥1.
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-low reset.
- `running_in` input 1: upstream `running` flag.
- `latency_in` input WIDTH: upstream `latency` value.
- `clear` input 1: synchronous flush of the accumulators, result slot and overrun flag.
- `stat_valid` output 1: the result slot holds a completed window.
- `stat_ready` input 1: consumer accepts the result.
- `stat_min` output WIDTH: smallest sample in the window.
- `stat_max` output WIDTH: largest sample in the window.
- `stat_avg` output WIDTH: sum >> LOG_WIN, truncated.
- `overrun` output 1: sticky flag. Set when a completed window was dropped.

## Operation
- **Sample event:** `running_q` is a registered copy of `running_in`, reset 0. A sample event occurs in any cycle where `running_q`=1 and `running_in`=0, i.e. a falling edge. The sample value is `latency_in` in that same cycle. That value is the final count, because upstream updates `latency` on the same edge that drops `running`.
- **Accumulators:**
  - `acc_min`: reset/clear value all-ones.
  - `acc_max`: reset/clear value 0.
  - `acc_sum`: WIDTH+LOG_WIN bits. Cannot overflow.
  - `acc_cnt`: LOG_WIN bits, reset/clear value 0.
- **Per sample:** min and max are updated by unsigned compare, the sample is added to the sum, and `acc_cnt` is incremented.
- **Window completion:** a sample event with `acc_cnt` = 2^LOG_WIN−1.
  - Final min, max and avg are computed including the current sample.
  - All accumulators return to their clear values in the same cycle, and `acc_cnt` wraps to 0.
- **Result slot FSM:** two states, EMPTY and FULL. `stat_valid` = (state==FULL).
  - EMPTY + completion → load slot, go to FULL.
  - FULL + handshake (`stat_valid`&&`stat_ready`) with no completion → EMPTY.
  - FULL + handshake + completion in the same cycle → load the new result, stay FULL. No overrun.
  - FULL + completion without handshake → keep the old result, discard the new one, set `overrun`, stay FULL.
- **Output stability:** `stat_min`/`stat_max`/`stat_avg` are registered and stable while `stat_valid`=1. They change only on a load.
- **Clear:** in a cycle with `clear`=1:
  - Accumulators go to their clear values, the FSM goes to EMPTY, and `overrun`=0.
  - A sample event in the same cycle is dropped.
  - `running_q` still tracks `running_in`.
- **Reset:** all registers return to reset values immediately, including mid-window. Partial windows are lost.
- **Upstream pulse width:** no edge means no sample. A `running_in` held high, or a start/stop pulse shorter than one cycle upstream, produces nothing.

## Timing
- **Reset values:** `stat_valid`=0, `stat_min`=0, `stat_max`=0, `stat_avg`=0, `overrun`=0.
- **Result latency:** a window completes in cycle t, and `stat_valid` and the outputs are valid from cycle t+1.
- **Acceptance:** the handshake completes on the clock edge where `stat_valid`&&`stat_ready`. `stat_valid` drops in the next cycle unless a new result loads on that edge.
- **`overrun` timing:** set at the edge ending the dropping cycle, visible from t+1. Cleared only by `clear` or reset.
- **Throughput:** one sample per cycle maximum. Back-to-back falling edges are impossible upstream, but the block must not depend on that.

## Structure
- **Shared package (`latency_pkg`):**
  - Slot-state enum (EMPTY/FULL).
  - A `WIN` = 2**LOG_WIN localparam helper.
  - `SUM_W` = WIDTH+LOG_WIN.
- **Sub-module `latency_window_acc`:** holds `acc_min`, `acc_max`, `acc_sum` and `acc_cnt`, and exposes a completion strobe plus the final min/max/avg. The top level keeps the edge detect, the slot FSM and `overrun`.

## Test plan
- LOG_WIN=2; samples 10, 20, 30, 41 via falling edges → `stat_valid` one cycle after the 4th edge; min=10, max=41, avg=25 (101>>2).
- `stat_ready`=0; two full windows (first 5,5,5,5, second 9,9,9,9) → outputs stay 5/5/5, `overrun`=1; after a handshake `stat_valid`=0.
- Second window completes in the same cycle as the handshake of the first → new result loaded, `stat_valid` stays 1, `overrun`=0.
- Two samples, then `clear` coincident with a third edge → after four more samples of 7, result 7/7/7 (pre-clear samples absent).
- All WIN samples = 2^WIDTH−1 → avg = 2^WIDTH−1 with no sum overflow; `running_in` held high 100 cycles → no sample.
- Assert `reset` mid-window and mid-FULL → all outputs 0 immediately; the next window computes only post-reset samples.
